// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, funct3 codes, state codes
// and the datapath mux/ALU selects consumed by the immediate generator and datapath.
package mc_controller_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALUOUT  = 2'b00,
    RES_MEMDATA = 2'b01,
    RES_ALU     = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    IMM_I    = 2'b00,
    IMM_S    = 2'b01,
    IMM_B    = 2'b10,
    IMM_NONE = 2'b11
  } imm_sel_t;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    alu_src_a_t  alu_src_a;
    alu_src_b_t  alu_src_b;
    alu_op_t     alu_op;
    result_src_t result_src;
    imm_sel_t    imm_sel;
  } ctrl_t;

  // Instruction class selected at the end of DECODE; unknown opcodes trap.
  function automatic state_t decode_next(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_STORE: return S_MEMADR;
      OP_RTYPE:          return S_EXECR;
      OP_ITYPE:          return S_EXECI;
      OP_BRANCH:         return S_BRANCH;
      default:           return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_retire_counter.sv
// Retired-instruction counter; wraps modulo 2**W and clears asynchronously.
module retire_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32 subset controller: Moore state register plus a state-decoded
// control word, with the retire counter as a sub-module.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             alu_zero,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_sel,
  output logic [3:0]       state_o,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t     state;
  ctrl_t      ctrl;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_store;
  logic       br_ok;
  logic       retire;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign is_store          = (opcode == OP_STORE);
  assign br_ok             = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE:   state <= decode_next(opcode);
        S_MEMADR:   state <= is_store ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= br_ok ? S_FETCH : S_TRAP;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    ctrl         = '0;
    ctrl.imm_sel = IMM_NONE;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_sel   = IMM_B;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.imm_sel   = is_store ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_MEMDATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.adr_src = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_FUNCT;
        ctrl.imm_sel   = IMM_I;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALU_SUB;
        ctrl.result_src = RES_ALUOUT;
        if (funct3 == F3_BEQ)      ctrl.pc_write = alu_zero;
        else if (funct3 == F3_BNE) ctrl.pc_write = !alu_zero;
      end
      default: ;
    endcase
  end

  // Write enables are gated by reset so an abandoned access cannot commit anything.
  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign adr_src    = ctrl.adr_src;
  assign ir_write   = ctrl.ir_write & rst_n;
  assign pc_write   = ctrl.pc_write & rst_n;
  assign reg_write  = ctrl.reg_write & rst_n;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign result_src = ctrl.result_src;
  assign imm_sel    = ctrl.imm_sel;
  assign state_o    = state;
  assign illegal    = (state == S_TRAP);

  assign retire = (state == S_MEMWB) ||
                  ((state == S_MEMWRITE) && mem_ready) ||
                  (state == S_ALUWB) ||
                  ((state == S_BRANCH) && br_ok);

  retire_counter #(.W(CNT_W)) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .count (instret)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: table-driven per-cycle vectors checked through an
// expected-value queue, plus hand-written reset and counter-wrap sequences.
module tb_mc_controller;

  localparam int CW = 4;
  localparam int W  = 4 + 17 + CW;

  // Control word order: mem_req mem_we adr_src ir_write pc_write reg_write a b op res imm illegal
  localparam logic [16:0] E_FETCH_W  = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b00,2'b11,1'b0};
  localparam logic [16:0] E_FETCH_G  = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b10,2'b00,2'b00,2'b11,1'b0};
  localparam logic [16:0] E_DECODE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b00,2'b00,2'b10,1'b0};
  localparam logic [16:0] E_MEMADR_L = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_MEMADR_S = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,2'b01,1'b0};
  localparam logic [16:0] E_MEMREAD  = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b11,1'b0};
  localparam logic [16:0] E_MEMWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b01,2'b11,1'b0};
  localparam logic [16:0] E_MEMWR    = {1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b11,1'b0};
  localparam logic [16:0] E_EXECR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,2'b11,1'b0};
  localparam logic [16:0] E_EXECI    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] E_ALUWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,2'b11,1'b0};
  localparam logic [16:0] E_BR_T     = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b01,2'b00,2'b11,1'b0};
  localparam logic [16:0] E_BR_N     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b01,2'b00,2'b11,1'b0};
  localparam logic [16:0] E_TRAP     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b11,1'b1};

  localparam logic [31:0] LD     = 32'h00412083;
  localparam logic [31:0] ST     = 32'h00112223;
  localparam logic [31:0] ADD    = 32'h002081B3;
  localparam logic [31:0] ADDI   = 32'h00108093;
  localparam logic [31:0] BEQ    = 32'h00208463;
  localparam logic [31:0] BNE    = 32'h00209463;
  localparam logic [31:0] BAD_BR = 32'h0020C463;
  localparam logic [31:0] ILL    = 32'h0000007F;

  typedef struct {
    logic [31:0]   instr;
    logic          mr;
    logic          az;
    logic [3:0]    st;
    logic [16:0]   ctrl;
    logic [CW-1:0] inst;
  } row_t;

  logic          clk;
  logic          rst_n;
  logic [31:0]   instr;
  logic          mem_ready;
  logic          alu_zero;
  logic          mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]    alu_src_a, alu_src_b, alu_op, result_src, imm_sel;
  logic [3:0]    state_o;
  logic          illegal;
  logic [CW-1:0] instret;
  logic [16:0]   act_ctrl;

  logic [W-1:0]  exp_q[$];
  row_t          tbl[$];
  int            checks;
  int            errors;
  int            m_inst;

  mc_controller #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .mem_ready  (mem_ready),
    .alu_zero   (alu_zero),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .imm_sel    (imm_sel),
    .state_o    (state_o),
    .illegal    (illegal),
    .instret    (instret)
  );

  assign act_ctrl = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                     alu_src_a, alu_src_b, alu_op, result_src, imm_sel, illegal};

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic v(input logic [31:0] i, input logic mr, input logic az,
                   input logic [3:0] st, input logic [16:0] c, input logic [CW-1:0] n);
    row_t r;
    r.instr = i; r.mr = mr; r.az = az; r.st = st; r.ctrl = c; r.inst = n;
    tbl.push_back(r);
  endtask

  // Driver: called #1 after a rising edge; checks on the falling edge.
  task automatic run_row(input logic [31:0] i, input logic mr, input logic az,
                         input logic [3:0] st, input logic [16:0] c, input logic [CW-1:0] n);
    logic [W-1:0] e;
    instr     = i;
    mem_ready = mr;
    alu_zero  = az;
    exp_q.push_back({st, c, n});
    @(negedge clk);
    e = exp_q.pop_front();
    chk("state", {28'd0, state_o}, {28'd0, e[W-1 -: 4]});
    chk("ctrl", {15'd0, act_ctrl}, {15'd0, e[CW +: 17]});
    chk("instret", {{(32-CW){1'b0}}, instret}, {{(32-CW){1'b0}}, e[CW-1:0]});
    @(posedge clk);
    #1;
  endtask

  task automatic do_release();
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_add(input logic [CW-1:0] n);
    run_row(ADD, 1'b1, 1'b0, 4'd0, E_FETCH_G, n);
    run_row(ADD, 1'b1, 1'b0, 4'd1, E_DECODE,  n);
    run_row(ADD, 1'b1, 1'b0, 4'd6, E_EXECR,   n);
    run_row(ADD, 1'b1, 1'b0, 4'd8, E_ALUWB,   n);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    instr     = '0;
    mem_ready = 1'b1;
    alu_zero  = 1'b0;

    // Reset state, before any clock edge, with mem_ready high
    #2;
    chk("rst_state", {28'd0, state_o}, 32'd0);
    chk("rst_instret", {{(32-CW){1'b0}}, instret}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_ir_write", {31'd0, ir_write}, 32'd0);
    chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk);
    #1;
    chk("rst_hold_state", {28'd0, state_o}, 32'd0);
    do_release();

    // Load, mem_ready high: 5 cycles
    v(LD, 1, 0, 0, E_FETCH_G, 0);
    v(LD, 1, 0, 1, E_DECODE, 0);
    v(LD, 1, 0, 2, E_MEMADR_L, 0);
    v(LD, 1, 0, 3, E_MEMREAD, 0);
    v(LD, 1, 0, 4, E_MEMWB, 0);
    // Store, 3 wait cycles in MEMWRITE: 7 cycles
    v(ST, 1, 0, 0, E_FETCH_G, 1);
    v(ST, 1, 0, 1, E_DECODE, 1);
    v(ST, 1, 0, 2, E_MEMADR_S, 1);
    v(ST, 0, 0, 5, E_MEMWR, 1);
    v(ST, 0, 0, 5, E_MEMWR, 1);
    v(ST, 0, 0, 5, E_MEMWR, 1);
    v(ST, 1, 0, 5, E_MEMWR, 1);
    // ADD with one fetch wait cycle
    v(ADD, 0, 0, 0, E_FETCH_W, 2);
    v(ADD, 1, 0, 0, E_FETCH_G, 2);
    v(ADD, 1, 0, 1, E_DECODE, 2);
    v(ADD, 1, 0, 6, E_EXECR, 2);
    v(ADD, 1, 0, 8, E_ALUWB, 2);
    // ADDI
    v(ADDI, 1, 0, 0, E_FETCH_G, 3);
    v(ADDI, 1, 0, 1, E_DECODE, 3);
    v(ADDI, 1, 0, 7, E_EXECI, 3);
    v(ADDI, 1, 0, 8, E_ALUWB, 3);
    // BEQ taken, BEQ not taken
    v(BEQ, 1, 1, 0, E_FETCH_G, 4);
    v(BEQ, 1, 1, 1, E_DECODE, 4);
    v(BEQ, 1, 1, 9, E_BR_T, 4);
    v(BEQ, 1, 0, 0, E_FETCH_G, 5);
    v(BEQ, 1, 0, 1, E_DECODE, 5);
    v(BEQ, 1, 0, 9, E_BR_N, 5);
    // BNE taken, BNE not taken
    v(BNE, 1, 0, 0, E_FETCH_G, 6);
    v(BNE, 1, 0, 1, E_DECODE, 6);
    v(BNE, 1, 0, 9, E_BR_T, 6);
    v(BNE, 1, 1, 0, E_FETCH_G, 7);
    v(BNE, 1, 1, 1, E_DECODE, 7);
    v(BNE, 1, 1, 9, E_BR_N, 7);
    // Unsupported branch funct3 traps without retiring
    v(BAD_BR, 1, 1, 0, E_FETCH_G, 8);
    v(BAD_BR, 1, 1, 1, E_DECODE, 8);
    v(BAD_BR, 1, 1, 9, E_BR_N, 8);
    v(BAD_BR, 1, 1, 10, E_TRAP, 8);
    v(ADD, 1, 0, 10, E_TRAP, 8);

    for (int k = 0; k < tbl.size(); k++)
      run_row(tbl[k].instr, tbl[k].mr, tbl[k].az, tbl[k].st, tbl[k].ctrl, tbl[k].inst);

    // Reset out of TRAP acts without a clock edge
    rst_n = 1'b0;
    #1;
    chk("trap_rst_state", {28'd0, state_o}, 32'd0);
    chk("trap_rst_illegal", {31'd0, illegal}, 32'd0);
    chk("trap_rst_instret", {{(32-CW){1'b0}}, instret}, 32'd0);
    do_release();

    // Retire one ADDI, then an illegal opcode: TRAP holds and instret freezes
    run_row(ADDI, 1'b1, 1'b0, 4'd0, E_FETCH_G, 0);
    run_row(ADDI, 1'b1, 1'b0, 4'd1, E_DECODE, 0);
    run_row(ADDI, 1'b1, 1'b0, 4'd7, E_EXECI, 0);
    run_row(ADDI, 1'b1, 1'b0, 4'd8, E_ALUWB, 0);
    run_row(ILL, 1'b1, 1'b0, 4'd0, E_FETCH_G, 1);
    run_row(ILL, 1'b1, 1'b0, 4'd1, E_DECODE, 1);
    for (int k = 0; k < 3; k++)
      run_row(LD, 1'b1, k[0], 4'd10, E_TRAP, 1);
    rst_n = 1'b0;
    #1;
    chk("ill_rst_state", {28'd0, state_o}, 32'd0);
    chk("ill_rst_illegal", {31'd0, illegal}, 32'd0);
    do_release();

    // Reset during an outstanding load read abandons it
    run_row(LD, 1'b1, 1'b0, 4'd0, E_FETCH_G, 0);
    run_row(LD, 1'b1, 1'b0, 4'd1, E_DECODE, 0);
    run_row(LD, 1'b1, 1'b0, 4'd2, E_MEMADR_L, 0);
    run_row(LD, 1'b0, 1'b0, 4'd3, E_MEMREAD, 0);
    mem_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("mid_rd_state", {28'd0, state_o}, 32'd0);
    chk("mid_rd_reg_write", {31'd0, reg_write}, 32'd0);
    chk("mid_rd_wr_en", {30'd0, ir_write, pc_write}, 32'd0);
    chk("mid_rd_adr_src", {31'd0, adr_src}, 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rd_hold", {28'd0, state_o, reg_write}, 32'd0);
    chk("mid_rd_instret", {{(32-CW){1'b0}}, instret}, 32'd0);
    do_release();

    // Counter wrap: 15 ADDs bring instret to all-ones, the 16th wraps it
    m_inst = 0;
    for (int k = 0; k < 16; k++) begin
      run_add(m_inst[CW-1:0]);
      m_inst = (m_inst + 1) % (1 << CW);
    end
    run_row(ADD, 1'b0, 1'b0, 4'd0, E_FETCH_W, m_inst[CW-1:0]);
    chk("wrap_instret", {{(32-CW){1'b0}}, instret}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port instr  input  32  current instruction register contents; decoded fields are opcode [6:0] and funct3 [14:12].
REQ-005 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-006 SHALL have port alu_zero  input  1  ALU result equals zero.
REQ-007 SHALL have port mem_req  output  1  memory access request, held until mem_ready.
REQ-008 SHALL have port mem_we  output  1  write qualifier for mem_req.
REQ-009 SHALL have port adr_src  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-010 SHALL have port ir_write, pc_write, reg_write  output  1 each  register write enables.
REQ-011 SHALL have port alu_src_a  output  2  00 = PC, 01 = old PC, 10 = rs1.
REQ-012 SHALL have port alu_src_b  output  2  00 = rs2, 01 = immediate, 10 = constant 4.
REQ-013 SHALL have port alu_op  output  2  00 = add, 01 = subtract, 10 = decode from funct fields.
REQ-014 SHALL have port result_src  output  2  00 = ALU result register, 01 = memory data, 10 = ALU output.
REQ-015 SHALL have port imm_sel  output  2  immediate generator format: 00 = I, 01 = S, 10 = B, 11 = none.
REQ-016 SHALL have ports state_o  output  4  current state code; illegal  output  1  trap flag; instret  output  CNT_W  retired-instruction count.

Function
REQ-017 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, TRAP; every output not listed for a state SHALL be 0, except imm_sel = 11.
REQ-018 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00; stays in FETCH while mem_ready=0. When mem_ready=1, SHALL assert ir_write=1 and pc_write=1 (PC+4) in that cycle, then go to DECODE.
REQ-019 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00, imm_sel=10 (branch target precompute). Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; any other opcode -> TRAP.
REQ-020 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00, imm_sel=00 for load, 01 for store. Next state is MEMREAD for load, MEMWRITE for store.
REQ-021 MEMREAD: mem_req=1, adr_src=1; waits for mem_ready, then goes to MEMWB. MEMWB: result_src=01, reg_write=1; then goes to FETCH.
REQ-022 MEMWRITE: mem_req=1, mem_we=1, adr_src=1; waits for mem_ready, then goes to FETCH.
REQ-023 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. EXECI: same signals except alu_src_b=01, imm_sel=00. Both go to ALUWB. ALUWB: result_src=00, reg_write=1; then goes to FETCH.
REQ-024 BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
- funct3 000 (BEQ): pc_write=alu_zero.
- funct3 001 (BNE): pc_write=!alu_zero.
- Then goes to FETCH. Any other funct3 goes to TRAP with pc_write=0.
REQ-025 TRAP: illegal=1, all enables 0; held until reset.
REQ-026 Latency with mem_ready tied high SHALL be: load 5, store 4, R/I-ALU 4, branch 3 cycles from FETCH entry to next FETCH entry. Each cycle with mem_ready=0 adds one cycle.
REQ-027 instret SHALL increment by 1 on the final cycle of each instruction (MEMWB, MEMWRITE with mem_ready, ALUWB, BRANCH non-trap). It SHALL wrap from all-ones to 0 and never increment in TRAP.
REQ-028 mem_req SHALL stay asserted, with a stable address select and mem_we, from assertion until the cycle mem_ready=1. mem_ready while mem_req=0 SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL immediately force FETCH, instret=0 and illegal=0, regardless of clk. Outputs SHALL take their FETCH values combinationally.
REQ-030 Reset asserted during an outstanding memory access SHALL abandon it; no write enable is asserted in the reset cycle.

Structure
REQ-031 Opcode constants, funct3 codes, the state encoding, and the alu_src/result_src/imm_sel/alu_op encodings SHALL reside in a shared package used by the immediate generator and datapath.
REQ-032 Next-state/output decode SHALL stay in one module. The instret counter SHALL be a sub-module, retire_counter.

Verification
REQ-033 Load 0x00412083 with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write only in MEMWB with result_src=01; instret 0->1.
REQ-034 Store 0x00112223 with mem_ready low 3 cycles in MEMWRITE -> mem_req/mem_we held 4 cycles; 7 cycles total; no reg_write.
REQ-035 BEQ 0x00208463 with alu_zero=1 then 0 -> pc_write=1 in BRANCH then 0; imm_sel=10 in DECODE.
REQ-036 Opcode 0x7F -> TRAP after DECODE; illegal=1 held; instret frozen; rst_n low -> FETCH, illegal=0.
REQ-037 instret preset to all-ones via forced sequence, then an ADD retires -> instret=0.
REQ-038 rst_n low mid-MEMREAD -> FETCH within the same cycle; no reg_write asserted.
